// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF, LS and memory-side signals of the shared memory port.
// The arbiter takes the slave view; the requesters and memory side take the master view.
interface mem_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int DATA_W = 16
);
  logic              if_r_v;
  logic [XLEN-1:0]   if_adr;
  logic              if_hit;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_r_v;
  logic              ls_w_v;
  logic [XLEN-1:0]   ls_adr;
  logic [XLEN-1:0]   ls_data;
  logic [3:0]        ls_strobe;
  logic              ls_hit;
  logic [DATA_W-1:0] ls_rdata;

  logic              m_r_v;
  logic              m_w_v;
  logic [XLEN-1:0]   m_adr;
  logic [XLEN-1:0]   m_data;
  logic [3:0]        m_strobe;
  logic              m_hit;
  logic [DATA_W-1:0] m_rdata;

  logic              busy;

  modport slave (
    input  if_r_v, if_adr,
    input  ls_r_v, ls_w_v, ls_adr, ls_data, ls_strobe,
    input  m_hit, m_rdata,
    output if_hit, if_rdata, ls_hit, ls_rdata,
    output m_r_v, m_w_v, m_adr, m_data, m_strobe, busy
  );

  modport master (
    output if_r_v, if_adr,
    output ls_r_v, ls_w_v, ls_adr, ls_data, ls_strobe,
    output m_hit, m_rdata,
    input  if_hit, if_rdata, ls_hit, ls_rdata,
    input  m_r_v, m_w_v, m_adr, m_data, m_strobe, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and load/store.
// LS has priority; a starvation counter forces an IF grant after STARVE_LIM LS grants.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t          state, state_nxt;
  logic [3:0]      starve_cnt, starve_cnt_nxt;
  logic            req_r, req_r_nxt;
  logic            req_w, req_w_nxt;
  logic [XLEN-1:0] req_adr, req_adr_nxt;
  logic [XLEN-1:0] req_data, req_data_nxt;
  logic [3:0]      req_strobe, req_strobe_nxt;

  logic ls_req;
  logic force_if;
  logic grant_ls;
  logic grant_if;

  always_comb begin
    ls_req   = bus.ls_r_v | bus.ls_w_v;
    force_if = bus.if_r_v && (starve_cnt == LIM);
    grant_ls = ls_req && !force_if;
    grant_if = !grant_ls && bus.if_r_v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      req_r      <= 1'b0;
      req_w      <= 1'b0;
      req_adr    <= '0;
      req_data   <= '0;
      req_strobe <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      req_r      <= req_r_nxt;
      req_w      <= req_w_nxt;
      req_adr    <= req_adr_nxt;
      req_data   <= req_data_nxt;
      req_strobe <= req_strobe_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    req_r_nxt      = req_r;
    req_w_nxt      = req_w;
    req_adr_nxt    = req_adr;
    req_data_nxt   = req_data;
    req_strobe_nxt = req_strobe;

    unique case (state)
      IDLE: begin
        if (grant_ls) begin
          state_nxt      = BUSY_LS;
          // Write wins when both LS read and write are raised together.
          req_w_nxt      = bus.ls_w_v;
          req_r_nxt      = !bus.ls_w_v;
          req_adr_nxt    = bus.ls_adr;
          req_data_nxt   = bus.ls_w_v ? bus.ls_data : '0;
          req_strobe_nxt = bus.ls_strobe;
          if (bus.if_r_v)
            starve_cnt_nxt = (starve_cnt == LIM) ? LIM : 4'(starve_cnt + 4'd1);
          else
            starve_cnt_nxt = '0;
        end else if (grant_if) begin
          state_nxt      = BUSY_IF;
          req_w_nxt      = 1'b0;
          req_r_nxt      = 1'b1;
          req_adr_nxt    = bus.if_adr;
          req_data_nxt   = '0;
          req_strobe_nxt = 4'b1111;
          starve_cnt_nxt = '0;
        end else begin
          starve_cnt_nxt = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (bus.m_hit)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory side is driven only from the captured request, never from live inputs.
  assign bus.busy     = (state != IDLE);
  assign bus.m_r_v    = bus.busy & req_r;
  assign bus.m_w_v    = bus.busy & req_w;
  assign bus.m_adr    = req_adr;
  assign bus.m_data   = req_data;
  assign bus.m_strobe = req_strobe;

  assign bus.if_hit   = (state == BUSY_IF) && bus.m_hit;
  assign bus.ls_hit   = (state == BUSY_LS) && bus.m_hit;
  assign bus.if_rdata = bus.if_hit ? bus.m_rdata : '0;
  assign bus.ls_rdata = bus.ls_hit ? bus.m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int XLEN   = 32;
  localparam int DATA_W = 16;
  localparam int LIM    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(XLEN), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.XLEN(XLEN), .DATA_W(DATA_W), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          w;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  strobe;
  } txn_t;

  // Reference model: who owns the port, the captured transaction, and how many
  // LS grants in a row have passed while IF was waiting.
  int   mdl_owner;   // 0 none, 1 IF, 2 LS
  int   mdl_streak;
  txn_t cur;
  bit   last_if_hit, last_ls_hit;
  bit   obs_if_hit, obs_ls_hit;

  int n_checks = 0;
  int n_pass   = 0;

  bit auto_drv = 0;
  int p_if = 50, p_ls = 50, p_hit = 40, p_rst = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic compare();
    bit exp_busy, e_ifh, e_lsh;
    exp_busy = (mdl_owner != 0);
    e_ifh    = (mdl_owner == 1) && (bus.m_hit === 1'b1);
    e_lsh    = (mdl_owner == 2) && (bus.m_hit === 1'b1);
    check("busy",     bus.busy,   exp_busy);
    check("m_r_v",    bus.m_r_v,  exp_busy && !cur.w);
    check("m_w_v",    bus.m_w_v,  exp_busy && cur.w);
    check("if_hit",   bus.if_hit, e_ifh);
    check("ls_hit",   bus.ls_hit, e_lsh);
    check("if_rdata", bus.if_rdata, e_ifh ? bus.m_rdata : 16'h0);
    check("ls_rdata", bus.ls_rdata, e_lsh ? bus.m_rdata : 16'h0);
    if (exp_busy) begin
      check("m_adr",    bus.m_adr,    cur.adr);
      check("m_data",   bus.m_data,   cur.data);
      check("m_strobe", bus.m_strobe, cur.strobe);
    end
    obs_if_hit = bus.if_hit;
    obs_ls_hit = bus.ls_hit;
  endtask

  task automatic model_update();
    bit ls_req;
    last_if_hit = 0;
    last_ls_hit = 0;
    ls_req = bus.ls_r_v | bus.ls_w_v;
    if (!rst_n) begin
      mdl_owner  = 0;
      mdl_streak = 0;
    end else if (mdl_owner == 0) begin
      if (ls_req && !(bus.if_r_v && mdl_streak == LIM)) begin
        mdl_owner  = 2;
        cur.w      = bus.ls_w_v;
        cur.adr    = bus.ls_adr;
        cur.data   = bus.ls_w_v ? bus.ls_data : 32'h0;
        cur.strobe = bus.ls_strobe;
        mdl_streak = bus.if_r_v ? ((mdl_streak + 1 > LIM) ? LIM : mdl_streak + 1) : 0;
      end else if (bus.if_r_v) begin
        mdl_owner  = 1;
        cur.w      = 0;
        cur.adr    = bus.if_adr;
        cur.data   = 32'h0;
        cur.strobe = 4'hF;
        mdl_streak = 0;
      end else begin
        mdl_streak = 0;
      end
    end else if (bus.m_hit) begin
      last_if_hit = (mdl_owner == 1);
      last_ls_hit = (mdl_owner == 2);
      mdl_owner   = 0;
    end
  endtask

  task automatic drive_random();
    int kind;
    rst_n       = ($urandom_range(0, 99) >= p_rst);
    bus.m_hit   = ($urandom_range(0, 99) < p_hit);
    bus.m_rdata = 16'($urandom);
    if (last_if_hit || !bus.if_r_v) begin
      bus.if_r_v = ($urandom_range(0, 99) < p_if);
      bus.if_adr = $urandom;
    end else if ($urandom_range(0, 3) == 0) begin
      bus.if_adr = $urandom;
    end
    if (last_ls_hit || !(bus.ls_r_v || bus.ls_w_v)) begin
      bus.ls_r_v = 0;
      bus.ls_w_v = 0;
      if ($urandom_range(0, 99) < p_ls) begin
        kind = $urandom_range(0, 2);
        bus.ls_r_v = (kind != 1);
        bus.ls_w_v = (kind != 0);
      end
      bus.ls_adr    = $urandom;
      bus.ls_data   = $urandom;
      bus.ls_strobe = 4'($urandom);
    end else if ($urandom_range(0, 3) == 0) begin
      bus.ls_adr    = $urandom;
      bus.ls_data   = $urandom;
      bus.ls_strobe = 4'($urandom);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
    if (auto_drv) drive_random();
  endtask

  task automatic idle_inputs();
    bus.if_r_v = 0; bus.if_adr = '0;
    bus.ls_r_v = 0; bus.ls_w_v = 0; bus.ls_adr = '0; bus.ls_data = '0; bus.ls_strobe = '0;
    bus.m_hit  = 0; bus.m_rdata = '0;
  endtask

  initial begin
    int nls;
    bit got_if;
    mdl_owner = 0; mdl_streak = 0;
    cur = '{w: 0, adr: '0, data: '0, strobe: '0};
    last_if_hit = 0; last_ls_hit = 0;
    idle_inputs();

    // Reset held two cycles with an IF request pending, then release.
    rst_n = 0; bus.if_r_v = 1; bus.if_adr = 32'h100;
    cyc(); cyc();
    rst_n = 1;
    cyc();
    check("rst_release_m_r_v", bus.m_r_v, 1);

    // IF read completes a few cycles later.
    cyc(); cyc();
    bus.m_hit = 1; bus.m_rdata = 16'hBEEF;
    #1;
    check("if_hit_beef",   bus.if_hit,   1);
    check("if_rdata_beef", bus.if_rdata, 16'hBEEF);
    check("if_strobe",     bus.m_strobe, 4'hF);
    check("if_no_ls_hit",  bus.ls_hit,   0);
    cyc();
    idle_inputs();
    cyc();

    // Simultaneous IF and LS write: LS first, IF after one idle cycle.
    bus.if_r_v = 1; bus.if_adr = 32'h40;
    bus.ls_w_v = 1; bus.ls_adr = 32'h204; bus.ls_data = 32'h12345678; bus.ls_strobe = 4'b1100;
    cyc();
    check("ls_first_w_v", bus.m_w_v, 1);
    check("ls_first_adr", bus.m_adr, 32'h204);
    bus.m_hit = 1;
    cyc();
    bus.ls_w_v = 0; bus.m_hit = 0;
    cyc();
    check("if_second_r_v", bus.m_r_v, 1);
    check("if_second_adr", bus.m_adr, 32'h40);
    bus.m_hit = 1;
    cyc();
    idle_inputs();
    cyc();

    // Starvation: LS writes continuously, IF held; two rounds of LIM LS then IF.
    rst_n = 0; cyc(); rst_n = 1;
    bus.ls_w_v = 1; bus.ls_adr = 32'h500; bus.ls_strobe = 4'h3; bus.if_r_v = 1; bus.m_hit = 1;
    for (int r = 0; r < 2; r++) begin
      nls = 0; got_if = 0;
      for (int i = 0; i < 60 && !got_if; i++) begin
        cyc();
        if (obs_ls_hit) nls++;
        if (obs_if_hit) got_if = 1;
      end
      check("starve_ls_grants", nls, LIM);
      check("starve_if_granted", got_if, 1);
    end
    idle_inputs();
    cyc(); cyc();

    // LS address changes while its transaction is in flight.
    bus.ls_r_v = 1; bus.ls_adr = 32'h300;
    cyc();
    bus.ls_adr = 32'h400;
    cyc(); cyc();
    check("hold_m_adr", bus.m_adr, 32'h300);
    bus.m_hit = 1;
    cyc();
    idle_inputs();
    cyc();

    // Reset during BUSY_IF, then a late m_hit.
    bus.if_r_v = 1; bus.if_adr = 32'h180;
    cyc(); cyc();
    rst_n = 0; bus.if_r_v = 0;
    cyc();
    rst_n = 1; bus.m_hit = 1; bus.m_rdata = 16'h5A5A;
    #1;
    check("late_hit_no_if_hit", bus.if_hit, 0);
    cyc();
    check("late_hit_idle", bus.busy, 0);
    idle_inputs();
    cyc();

    // Randomized traffic under several mixes.
    auto_drv = 1;
    p_if = 60; p_ls = 60; p_hit = 40; p_rst = 0;
    repeat (1500) cyc();
    p_if = 90; p_ls = 95; p_hit = 80; p_rst = 0;
    repeat (1500) cyc();
    p_if = 40; p_ls = 40; p_hit = 20; p_rst = 3;
    repeat (1500) cyc();
    auto_drv = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
